// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  localparam int REGFILE_AW = 5;
  localparam int REGFILE_DW = 32;

  typedef enum logic [0:0] {
    DUMP_IDLE = 1'b0,
    DUMP_SCAN = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Debug dump sequencer: walks every register index out over a valid/ready
// handshake. The parent supplies the read value of next_idx so the captured
// beat data matches what a normal read port would see in the accepting cycle.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REGFILE_AW,
  parameter int DATA_WIDTH    = REGFILE_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dump_req,
  input  logic                     dump_ready,
  input  logic [DATA_WIDTH-1:0]    next_value,
  output logic [ADDRESS_WIDTH-1:0] next_idx,
  output logic                     dump_busy,
  output logic                     dump_valid,
  output logic [ADDRESS_WIDTH-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0]    dump_data
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = {ADDRESS_WIDTH{1'b1}};
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    ZERO_DAT = {DATA_WIDTH{1'b0}};

  dump_state_t              state_r, state_s;
  logic [ADDRESS_WIDTH-1:0] idx_r, idx_s;
  logic [DATA_WIDTH-1:0]    data_r, data_s;

  // Index the parent must read for the capture on the next accepted beat.
  assign next_idx   = idx_r + ADDRESS_WIDTH'(1);
  assign dump_busy  = (state_r == DUMP_SCAN);
  assign dump_valid = (state_r == DUMP_SCAN);
  assign dump_idx   = idx_r;
  assign dump_data  = data_r;

  // State, beat index and captured data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DUMP_IDLE;
      idx_r   <= ZERO_IDX;
      data_r  <= ZERO_DAT;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
    end
  end

  // Next-state logic: start from IDLE only, advance on accept, hold on stall.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    data_s  = data_r;
    case (state_r)
      DUMP_IDLE: begin
        if (dump_req) begin
          state_s = DUMP_SCAN;
          idx_s   = ZERO_IDX;
          data_s  = ZERO_DAT;   // beat 0 is x0, always zero
        end else begin
          state_s = DUMP_IDLE;
        end
      end
      DUMP_SCAN: begin
        if (dump_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = DUMP_IDLE;
            idx_s   = ZERO_IDX;
            data_s  = ZERO_DAT;
          end else begin
            idx_s  = next_idx;
            data_s = next_value;
          end
        end else begin
          state_s = DUMP_SCAN;  // stalled beat stays frozen
        end
      end
      default: begin
        state_s = DUMP_IDLE;
        idx_s   = ZERO_IDX;
        data_s  = ZERO_DAT;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_READ combinational reads, one write,
// hardwired-zero x0, a0 tap and a streaming debug dump port.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding on the
// read ports and the dump capture; a0 is never bypassed).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REGFILE_AW,
  parameter int DATA_WIDTH    = REGFILE_DW,
  parameter int NUM_READ      = 2,
  parameter int A0_INDEX      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  input  logic                              we,
  input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic [DATA_WIDTH-1:0]             a0,
  input  logic                              dump_req,
  output logic                              dump_busy,
  output logic                              dump_valid,
  input  logic                              dump_ready,
  output logic [ADDRESS_WIDTH-1:0]          dump_idx,
  output logic [DATA_WIDTH-1:0]             dump_data
);

  localparam int                       DEPTH    = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_INDEX);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    ZERO_DAT = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0]    regs_r [DEPTH];
  logic                     wr_ok_s;
  logic [ADDRESS_WIDTH-1:0] scan_idx_s;
  logic                     scan_hit_s;
  logic [DATA_WIDTH-1:0]    scan_value_s;

  // Read selection shared by every read path: x0 forced to zero, then
  // forwarding (hit is tied low when bypass is compiled out), then the array.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDRESS_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]    arr_val,
    input logic                     hit,
    input logic [DATA_WIDTH-1:0]    byp_val
  );
    logic [DATA_WIDTH-1:0] v;
    if (idx == ZERO_IDX) begin
      v = ZERO_DAT;
    end else if (hit) begin
      v = byp_val;
    end else begin
      v = arr_val;
    end
    return v;
  endfunction

  // Writes to x0 are dropped here so the array entry 0 never leaves zero.
  assign wr_ok_s = we && (wr_addr != ZERO_IDX);

  // Register array: asynchronous clear, single synchronous write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= ZERO_DAT;
      end
    end else if (wr_ok_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr_s;
    logic                     hit_s;
    assign addr_s = rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
    assign hit_s = wr_ok_s && (wr_addr == addr_s);
`else
    assign hit_s = 1'b0;
`endif
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
      read_sel(addr_s, regs_r[addr_s], hit_s, wr_data);
  end

  // a0 is a raw tap of the array and deliberately ignores forwarding.
  assign a0 = regs_r[A0_IDX];

`ifdef REGFILE_BYPASS_EN
  assign scan_hit_s = wr_ok_s && (wr_addr == scan_idx_s);
`else
  assign scan_hit_s = 1'b0;
`endif
  assign scan_value_s = read_sel(scan_idx_s, regs_r[scan_idx_s], scan_hit_s, wr_data);

  regfile_dump_fsm #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_dump_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .next_value (scan_value_s),
    .next_idx   (scan_idx_s),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

endmodule
